// File: rtl/key_xlate_call_arbiter.sv
// rtl/key_xlate_call_arbiter.sv - round-robin arbiter sharing one key translator call port
// One call in flight; a watchdog substitutes TIMEOUT_VALUE if the callee never completes.
module key_xlate_call_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_VALUE  = 32'hFFFF_FFFF
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_code,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [31:0]            rsp_data,
   output logic                   rsp_err,
   output logic                   call_start,
   input  logic                   call_busy,
   output logic [31:0]            call_code,
   input  logic                   call_done,
   output logic                   call_stall,
   input  logic [31:0]            call_returndata,
   output logic [31:0]            call_cnt,
   output logic [15:0]            timeout_cnt
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, owner, winner;
   logic [IW:0]   idx;
   logic          found;
   logic [31:0]   code_q, timer;
   logic          timeout_hit;

   // Search starts just after the last served owner, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NUM_REQ))
            idx = idx - (IW+1)'(NUM_REQ);
         if (!found && req_valid[idx[IW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IW-1:0];
         end
      end
   end

   assign timeout_hit = (state == S_WAIT) && !call_done && (timer == 32'(TIMEOUT_CYCLES - 1));
   assign call_code   = code_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      rsp_valid  = '0;
      call_start = 1'b0;
      call_stall = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by resetn so nothing is granted while reset is held.
            if (found && resetn) begin
               req_ready[winner] = 1'b1;
               state_nxt         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            call_start = 1'b1;
            call_stall = 1'b1;
            if (!call_busy)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (call_done || timeout_hit)
               state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid[owner] = 1'b1;
            call_stall       = 1'b1;
            if (rsp_ready[owner])
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ptr         <= IW'(NUM_REQ - 1);
         owner       <= '0;
         code_q      <= '0;
         timer       <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         call_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  owner  <= winner;
                  code_q <= req_code[32*winner +: 32];
               end
            end
            S_ISSUE: begin
               if (!call_busy)
                  timer <= '0;
            end
            S_WAIT: begin
               // A done arriving on the final watchdog cycle still counts as a real result.
               if (call_done) begin
                  rsp_data <= call_returndata;
                  rsp_err  <= 1'b0;
                  call_cnt <= call_cnt + 32'd1;
               end else if (timeout_hit) begin
                  rsp_data <= TIMEOUT_VALUE;
                  rsp_err  <= 1'b1;
                  if (timeout_cnt != 16'hFFFF)
                     timeout_cnt <= timeout_cnt + 16'd1;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready[owner])
                  ptr <= owner;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_key_xlate_call_arbiter.sv
// tb/tb_key_xlate_call_arbiter.sv - scoreboard bench for key_xlate_call_arbiter
module tb_key_xlate_call_arbiter;

   localparam int N = 4;

   logic              clock = 1'b0;
   logic              resetn;
   logic [N-1:0]      req_valid;
   logic [32*N-1:0]   req_code;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_err;
   logic              call_start;
   logic              call_busy;
   logic [31:0]       call_code;
   logic              call_done;
   logic              call_stall;
   logic [31:0]       call_returndata;
   logic [31:0]       call_cnt;
   logic [15:0]       timeout_cnt;

   always #5 clock = ~clock;

   key_xlate_call_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (16),
      .TIMEOUT_VALUE  (32'hFFFF_FFFF)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .req_valid       (req_valid),
      .req_code        (req_code),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .call_start      (call_start),
      .call_busy       (call_busy),
      .call_code       (call_code),
      .call_done       (call_done),
      .call_stall      (call_stall),
      .call_returndata (call_returndata),
      .call_cnt        (call_cnt),
      .timeout_cnt     (timeout_cnt)
   );

   typedef struct {
      int          owner;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input int o, input logic [31:0] d, input logic e);
      exp_t x;
      x.owner = o;
      x.data  = d;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if ((rsp_valid & rsp_ready) != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.owner));
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   // Callee model: returns code ^ 0x41 cb_delay cycles after start is accepted.
   int          cb_delay   = 1;
   bit          cb_never   = 1'b0;
   int          wait_n     = 0;
   logic [31:0] cb_ret     = '0;
   int          stray_cnt  = 0;
   int          stray_seen = 0;

   initial begin : callee
      call_done       = 1'b0;
      call_returndata = '0;
      forever begin
         @(negedge clock);
         call_done = 1'b0;
         if (wait_n > 0) begin
            wait_n--;
            if (wait_n == 0) begin
               call_done       = 1'b1;
               call_returndata = cb_ret;
            end
         end
         if (stray_cnt != stray_seen) begin
            stray_seen      = stray_cnt;
            call_done       = 1'b1;
            call_returndata = 32'hDEAD_BEEF;
         end
         if (call_start && !call_busy && !cb_never) begin
            wait_n = cb_delay;
            cb_ret = call_code ^ 32'h41;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic issue(input int idx, input logic [31:0] code);
      int n;
      n = 0;
      req_code[32*idx +: 32] = code;
      req_valid[idx] = 1'b1;
      do begin
         @(negedge clock);
         n++;
      end while (req_ready[idx] !== 1'b1 && n < 50);
      chk("grant", 32'(req_ready), 32'(1 << idx));
      @(posedge clock);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0)
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (rsp_valid == '0 && n < 100);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
      chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
      chk({tag, "_rsp_data"},    rsp_data,         32'd0);
      chk({tag, "_rsp_err"},     32'(rsp_err),     32'd0);
      chk({tag, "_call_start"},  32'(call_start),  32'd0);
      chk({tag, "_call_code"},   call_code,        32'd0);
      chk({tag, "_call_stall"},  32'(call_stall),  32'd0);
      chk({tag, "_call_cnt"},    call_cnt,         32'd0);
      chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
   endtask

   initial begin : main
      int n;
      resetn    = 1'b0;
      req_valid = 4'hF;
      req_code  = '0;
      rsp_ready = '1;
      call_busy = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_all_zero("reset");
      req_valid = '0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      cyc(1);

      // Fairness: all four held, expect 0,1,2,3,0,1,2,3
      cb_delay = 1;
      for (int i = 0; i < N; i++)
         req_code[32*i +: 32] = 32'h100 + 32'(i);
      for (int g = 0; g < 8; g++)
         push(g % 4, (32'h100 + 32'(g % 4)) ^ 32'h41, 1'b0);
      req_valid = 4'hF;
      for (int g = 0; g < 8; g++) begin
         n = 0;
         do begin
            @(negedge clock);
            n++;
         end while (req_ready == '0 && n < 20);
         chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
         @(posedge clock);
         #1;
         if (g == 7)
            req_valid = '0;
      end
      drain();
      chk("fair_call_cnt", call_cnt, 32'd8);

      // Single request, callee answers after 3 cycles
      cb_delay = 3;
      push(0, 32'h0000_0000, 1'b0);
      issue(0, 32'h41);
      drain();
      chk("single_call_cnt", call_cnt, 32'd9);

      // Busy back-pressure in ISSUE; granted slice changes must not leak through
      call_busy = 1'b1;
      cb_delay  = 1;
      push(2, 32'h2263, 1'b0);
      issue(2, 32'h2222);
      req_code[64 +: 32] = 32'hBAD0_0000;
      repeat (5) begin
         @(negedge clock);
         chk("busy_start", 32'(call_start), 32'd1);
         chk("busy_code", call_code, 32'h2222);
         chk("busy_stall", 32'(call_stall), 32'd1);
         @(posedge clock);
         #1;
      end
      call_busy = 1'b0;
      drain();
      chk("busy_call_cnt", call_cnt, 32'd10);

      // Watchdog: callee silent, 16 WAIT cycles then TIMEOUT_VALUE
      cb_never = 1'b1;
      push(1, 32'hFFFF_FFFF, 1'b1);
      issue(1, 32'h77);
      wait_rsp(n);
      chk("timeout_latency", 32'(n), 32'd18);
      drain();
      chk("timeout_cnt", 32'(timeout_cnt), 32'd1);
      chk("timeout_call_cnt", call_cnt, 32'd10);
      stray_cnt++;
      cyc(4);
      chk("stray_call_cnt", call_cnt, 32'd10);
      chk("stray_timeout_cnt", 32'(timeout_cnt), 32'd1);
      chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_call_stall", 32'(call_stall), 32'd0);
      cb_never = 1'b0;

      // Response stall: held response, no new grant while another requester waits
      rsp_ready = '0;
      cb_delay  = 1;
      push(3, 32'h3041, 1'b0);
      issue(3, 32'h3000);
      req_valid[0] = 1'b1;
      push(0, 32'h0000_0000, 1'b0);
      wait_rsp(n);
      repeat (10) begin
         chk("stall_rsp_valid", 32'(rsp_valid), 32'h8);
         chk("stall_rsp_data", rsp_data, 32'h3041);
         chk("stall_call_stall", 32'(call_stall), 32'd1);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      rsp_ready = '1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (req_ready[0] !== 1'b1 && n < 20);
      chk("grant_after_stall", 32'(req_ready), 32'd1);
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      drain();
      chk("stall_call_cnt", call_cnt, 32'd12);

      // Asynchronous reset in WAIT, then a clean grant to requester 1
      cb_never = 1'b1;
      issue(1, 32'h55);
      cyc(3);
      #2;
      resetn = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clock);
      #1;
      resetn   = 1'b1;
      cb_never = 1'b0;
      cb_delay = 1;
      push(1, 32'h1275, 1'b0);
      issue(1, 32'h1234);
      wait_rsp(n);
      chk("ideal_latency", 32'(n), 32'd3);
      drain();
      chk("post_rst_call_cnt", call_cnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

endmodule
